img_lut_bank_corrector: RTL and testbench

Per-channel look-up-table pixel corrector for AXI4-Stream video. It is the successor of the shared-LUT gamma stage. Each channel has its own table, held in two banks (active and shadow) and reloaded from a write port while video flows. Bank swaps are frame-synchronous. The block sits between the demosaic/colour stages and the output formatter.

---
 rtl/img_lut_bank_corrector_pkg.sv | 16 +
 rtl/img_lut_bank_corrector_if.sv | 29 ++
 rtl/img_lut_bank_corrector_ram.sv | 29 ++
 rtl/img_lut_bank_corrector.sv | 152 +++++++++++++++
 tb/tb_img_lut_bank_corrector.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_lut_bank_corrector_pkg.sv
// Shared types for the banked per-channel LUT corrector.
// Holds the tdata width helper, the swap-state enum and the bank index type.
package img_lut_pkg;

  function automatic int tdata_width(int px, int ch);
    return ((px * ch + 7) / 8) * 8;
  endfunction

  typedef enum logic {
    SWAP_IDLE,
    SWAP_PENDING
  } swap_state_t;

  typedef logic bank_t;

endpackage

// File: rtl/img_lut_bank_corrector_if.sv
// AXI4-Stream bundle used on both video sides of the corrector.
// Ports: tvalid/tready handshake, tdata, tstrb, tkeep, tlast, tuser, tid, tdest.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 4,
  parameter int TDEST_WIDTH = 4
) ();
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic                     tuser;
  logic [TID_WIDTH-1:0]     tid;
  logic [TDEST_WIDTH-1:0]   tdest;

  modport master (
    output tvalid, tdata, tstrb, tkeep,
    output tlast, tuser, tid, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep,
    input  tlast, tuser, tid, tdest,
    output tready
  );
endinterface

// File: rtl/img_lut_bank_corrector_ram.sv
// Dual-bank simple dual-port table RAM, addressed {bank, index}.
// Ports: clk_i, write port (wr_i/bank/addr/data), read port with enable and registered data.
module img_lut_bank_ram
  import img_lut_pkg::*;
#(
  parameter int PX_WIDTH = 10
) (
  input  logic                clk_i,
  input  logic                wr_i,
  input  bank_t               wr_bank_i,
  input  logic [PX_WIDTH-1:0] wr_addr_i,
  input  logic [PX_WIDTH-1:0] wr_data_i,
  input  logic                rd_en_i,
  input  bank_t               rd_bank_i,
  input  logic [PX_WIDTH-1:0] rd_addr_i,
  output logic [PX_WIDTH-1:0] rd_data_o
);

  logic [PX_WIDTH-1:0] mem [2**(PX_WIDTH+1)];

  always_ff @(posedge clk_i) begin
    if (wr_i) mem[{wr_bank_i, wr_addr_i}] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rd_en_i) rd_data_o <= mem[{rd_bank_i, rd_addr_i}];
  end

endmodule

// File: rtl/img_lut_bank_corrector.sv
// Per-channel banked LUT corrector with frame-synchronous bank swap.
// Ports: clk_i, rst_i, LUT write port, swap control/status, bypass_i, video_i/video_o streams.
module img_lut_bank_corrector
  import img_lut_pkg::*;
#(
  parameter int PX_WIDTH        = 10,
  parameter int CHANNELS_AMOUNT = 3,
  parameter int CH_SEL_WIDTH    =
    (CHANNELS_AMOUNT > 1) ? $clog2(CHANNELS_AMOUNT) : 1,
  parameter int TID_WIDTH       = 4,
  parameter int TDEST_WIDTH     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       lut_wr_i,
  output logic                       lut_wr_ready_o,
  input  logic [CH_SEL_WIDTH-1:0]    lut_wr_chan_i,
  input  logic [PX_WIDTH-1:0]        lut_wr_addr_i,
  input  logic [PX_WIDTH-1:0]        lut_wr_data_i,
  input  logic                       swap_req_i,
  output logic                       swap_pending_o,
  output logic                       active_bank_o,
  input  logic [CHANNELS_AMOUNT-1:0] bypass_i,
  axi4_stream_if.slave               video_i,
  axi4_stream_if.master              video_o
);

  localparam int TDATA_WIDTH = tdata_width(PX_WIDTH, CHANNELS_AMOUNT);
  localparam int PW = PX_WIDTH * CHANNELS_AMOUNT;

  swap_state_t state, state_n;
  bank_t       bank, bank_n, rd_bank, wr_bank;
  logic        en, acc, sof, wr_ok;

  logic                       s1_valid, s1_user, s1_last;
  logic [TID_WIDTH-1:0]       s1_id;
  logic [TDEST_WIDTH-1:0]     s1_dest;
  logic [CHANNELS_AMOUNT-1:0] s1_byp;
  logic [PW-1:0]              s1_px;

  logic                       s2_valid, s2_user, s2_last;
  logic [TID_WIDTH-1:0]       s2_id;
  logic [TDEST_WIDTH-1:0]     s2_dest;
  logic [TDATA_WIDTH-1:0]     s2_data;

  logic [PX_WIDTH-1:0] rd_data [CHANNELS_AMOUNT];
  logic [PW-1:0]       px_flat;
  logic                unused;

  assign en  = !s2_valid || video_o.tready;
  assign acc = video_i.tvalid && en;
  assign sof = acc && video_i.tuser;

  // The swapping beat is already looked up in the new bank.
  assign rd_bank = bank ^ bank_t'(state == SWAP_PENDING && sof);
  assign wr_bank = ~bank;
  assign wr_ok   = lut_wr_i && (state == SWAP_IDLE);

  always_comb begin
    state_n = state;
    bank_n  = bank;
    unique case (state)
      SWAP_IDLE:
        if (swap_req_i) state_n = SWAP_PENDING;
      SWAP_PENDING:
        if (sof) begin
          state_n = SWAP_IDLE;
          bank_n  = ~bank;
        end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= SWAP_IDLE;
      bank  <= 1'b0;
    end else begin
      state <= state_n;
      bank  <= bank_n;
    end
  end

  // Channel indices past the last table match no RAM and are dropped.
  for (genvar g = 0; g < CHANNELS_AMOUNT; g++) begin : g_ch
    img_lut_bank_ram #(
      .PX_WIDTH (PX_WIDTH)
    ) u_ram (
      .clk_i     (clk_i),
      .wr_i      (wr_ok && lut_wr_chan_i == CH_SEL_WIDTH'(g)),
      .wr_bank_i (wr_bank),
      .wr_addr_i (lut_wr_addr_i),
      .wr_data_i (lut_wr_data_i),
      .rd_en_i   (en),
      .rd_bank_i (rd_bank),
      .rd_addr_i (video_i.tdata[PX_WIDTH*g +: PX_WIDTH]),
      .rd_data_o (rd_data[g])
    );

    assign px_flat[PX_WIDTH*g +: PX_WIDTH] =
      s1_byp[g] ? s1_px[PX_WIDTH*g +: PX_WIDTH] : rd_data[g];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_user  <= 1'b0;
      s1_last  <= 1'b0;
      s1_id    <= '0;
      s1_dest  <= '0;
      s1_byp   <= '0;
      s1_px    <= '0;
      s2_valid <= 1'b0;
      s2_user  <= 1'b0;
      s2_last  <= 1'b0;
      s2_id    <= '0;
      s2_dest  <= '0;
      s2_data  <= '0;
    end else if (en) begin
      s1_valid <= video_i.tvalid;
      s1_user  <= video_i.tuser;
      s1_last  <= video_i.tlast;
      s1_id    <= video_i.tid;
      s1_dest  <= video_i.tdest;
      s1_byp   <= bypass_i;
      s1_px    <= video_i.tdata[PW-1:0];
      s2_valid <= s1_valid;
      s2_user  <= s1_user;
      s2_last  <= s1_last;
      s2_id    <= s1_id;
      s2_dest  <= s1_dest;
      s2_data  <= TDATA_WIDTH'(px_flat);
    end
  end

  assign video_i.tready = en;

  assign video_o.tvalid = s2_valid;
  assign video_o.tdata  = s2_data;
  assign video_o.tstrb  = '1;
  assign video_o.tkeep  = '1;
  assign video_o.tlast  = s2_last;
  assign video_o.tuser  = s2_user;
  assign video_o.tid    = s2_id;
  assign video_o.tdest  = s2_dest;

  assign lut_wr_ready_o = (state == SWAP_IDLE);
  assign swap_pending_o = (state == SWAP_PENDING);
  assign active_bank_o  = bank;

  assign unused = &{1'b0, video_i.tstrb, video_i.tkeep, video_i.tdata};

endmodule

// File: tb/tb_img_lut_bank_corrector.sv
// Randomized self-checking bench for img_lut_bank_corrector.
// Compares every output beat and status flag against a table-level reference model.
module tb_img_lut_bank_corrector;
  localparam int PXW = 10;
  localparam int CH  = 3;
  localparam int DW  = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lut_wr = 1'b0;
  logic       lut_wr_ready;
  logic [1:0] wr_chan = '0;
  logic [9:0] wr_addr = '0;
  logic [9:0] wr_data = '0;
  logic       swap_req = 1'b0;
  logic       swap_pending;
  logic       active_bank;
  logic [2:0] bypass = '0;

  always #5 clk = ~clk;

  axi4_stream_if #(.TDATA_WIDTH(DW)) vin ();
  axi4_stream_if #(.TDATA_WIDTH(DW)) vout ();

  img_lut_bank_corrector dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .lut_wr_i       (lut_wr),
    .lut_wr_ready_o (lut_wr_ready),
    .lut_wr_chan_i  (wr_chan),
    .lut_wr_addr_i  (wr_addr),
    .lut_wr_data_i  (wr_data),
    .swap_req_i     (swap_req),
    .swap_pending_o (swap_pending),
    .active_bank_o  (active_bank),
    .bypass_i       (bypass),
    .video_i        (vin),
    .video_o        (vout)
  );

  typedef struct {
    logic [31:0] data;
    bit          user;
    bit          last;
    logic [3:0]  id;
    logic [3:0]  dest;
    int          stamp;
  } beat_t;

  int    checks = 0;
  int    failures = 0;
  int    lut [CH][2][1024];
  bit    m_pend = 0;
  bit    m_bank = 0;
  beat_t expq [$];
  int    ncyc = 0;
  bit    lat_chk = 1;
  bit    rand_rdy = 0;
  bit    hold = 0;
  logic [31:0] hold_data;
  bit    hold_user, hold_last;
  bit    in_acc, wr_acc;
  int    tlast_cnt = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_px(logic [31:0] d, bit b,
                                           logic [2:0] byp);
    logic [31:0] r;
    r = '0;
    for (int g = 0; g < CH; g++) begin
      int v;
      v = int'(d[10*g +: 10]);
      r[10*g +: 10] = byp[g] ? d[10*g +: 10] : 10'(lut[g][b][v]);
    end
    return r;
  endfunction

  // One clock: starts and ends 1 time unit after a rising edge.
  task automatic cyc();
    beat_t e;
    bit    b;
    if (rand_rdy) vout.tready = 1'($urandom_range(1));
    #1;
    in_acc = 0;
    wr_acc = 0;
    if (!rst) begin
      check("pending", swap_pending, m_pend);
      check("bank", active_bank, m_bank);
      check("wr_ready", lut_wr_ready, !m_pend);
      if (hold) begin
        check("stall_valid", vout.tvalid, 1);
        check("stall_data", vout.tdata, hold_data);
        check("stall_user", vout.tuser, hold_user);
        check("stall_last", vout.tlast, hold_last);
      end
      if (vout.tvalid && vout.tready) begin
        if (expq.size() == 0) begin
          check("extra_beat", vout.tvalid, 0);
        end else begin
          e = expq.pop_front();
          check("data", vout.tdata, e.data);
          check("user", vout.tuser, e.user);
          check("last", vout.tlast, e.last);
          check("id", vout.tid, e.id);
          check("dest", vout.tdest, e.dest);
          if (lat_chk) check("latency", ncyc - e.stamp, 2);
          if (vout.tlast) tlast_cnt++;
        end
      end
      hold = vout.tvalid && !vout.tready;
      hold_data = vout.tdata;
      hold_user = vout.tuser;
      hold_last = vout.tlast;
      in_acc = vin.tvalid && vin.tready;
      wr_acc = lut_wr && lut_wr_ready;
      if (in_acc) begin
        b = m_bank ^ (m_pend && vin.tuser);
        e.data  = model_px(vin.tdata, b, bypass);
        e.user  = vin.tuser;
        e.last  = vin.tlast;
        e.id    = vin.tid;
        e.dest  = vin.tdest;
        e.stamp = ncyc;
        expq.push_back(e);
      end
      if (wr_acc && int'(wr_chan) < CH)
        lut[wr_chan][!m_bank][wr_addr] = int'(wr_data);
      if (m_pend && in_acc && vin.tuser) begin
        m_bank = !m_bank;
        m_pend = 0;
      end else if (!m_pend && swap_req) begin
        m_pend = 1;
      end
    end else begin
      expq.delete();
      hold = 0;
      m_pend = 0;
      m_bank = 0;
    end
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc();
  endtask

  task automatic lut_write(int ch, int a, int d);
    int n;
    lut_wr  = 1'b1;
    wr_chan = 2'(ch);
    wr_addr = 10'(a);
    wr_data = 10'(d);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!wr_acc && n < 100);
    if (!wr_acc) check("wr_timeout", lut_wr_ready, 1);
    lut_wr = 1'b0;
  endtask

  task automatic send(logic [29:0] px, bit user, bit last);
    int n;
    vin.tvalid = 1'b1;
    vin.tdata  = {2'($urandom_range(3)), px};
    vin.tuser  = user;
    vin.tlast  = last;
    vin.tid    = 4'($urandom);
    vin.tdest  = 4'($urandom);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!in_acc && n < 200);
    if (!in_acc) check("send_timeout", vin.tready, 1);
    vin.tvalid = 1'b0;
    vin.tuser  = 1'b0;
    vin.tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    check("drain", expq.size(), 0);
  endtask

  function automatic logic [29:0] rpx();
    return {10'($urandom), 10'($urandom), 10'($urandom)};
  endfunction

  initial begin
    vin.tvalid  = 1'b0;
    vin.tdata   = '0;
    vin.tstrb   = '1;
    vin.tkeep   = '1;
    vin.tuser   = 1'b0;
    vin.tlast   = 1'b0;
    vin.tid     = '0;
    vin.tdest   = '0;
    vout.tready = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
    rst = 1'b0;
    check("rst_valid", vout.tvalid, 0);
    check("rst_data", vout.tdata, 0);
    check("rst_user", vout.tuser, 0);
    check("rst_last", vout.tlast, 0);
    check("rst_strb", {vout.tstrb, vout.tkeep}, 8'hFF);

    // bank 1: ch0 identity+1 saturating, ch1 identity, ch2 random
    for (int a = 0; a < 1024; a++) begin
      lut_write(0, a, (a < 1023) ? a + 1 : 1023);
      lut_write(1, a, a);
      lut_write(2, a, int'($urandom_range(1023)));
    end
    lut_write(3, 100, 0);
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    send({10'($urandom), 10'($urandom), 10'd100}, 1, 0);
    check("t1_bank", active_bank, 1);
    cyc();
    check("t1_valid", vout.tvalid, 1);
    check("t1_ch0", vout.tdata[9:0], 101);
    for (int i = 0; i < 6; i++) send(rpx(), 0, i == 5);
    drain();

    // bank 0: inverting tables
    for (int a = 0; a < 1024; a++)
      for (int g = 0; g < CH; g++) lut_write(g, a, 1023 - a);
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    send(rpx(), 1, 0);
    drain();

    // write held while a swap is pending
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    lut_wr  = 1'b1;
    wr_chan = 2'd0;
    wr_addr = 10'd7;
    wr_data = 10'd555;
    idle(3);
    check("t2_ready_low", lut_wr_ready, 0);
    send(rpx(), 1, 0);
    check("t2_ready_high", lut_wr_ready, 1);
    cyc();
    check("t2_wr_done", wr_acc, 1);
    lut_wr = 1'b0;
    drain();
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    send({10'($urandom), 10'($urandom), 10'd7}, 1, 0);
    cyc();
    check("t2_bank0_wr", vout.tdata[9:0], 555);
    drain();

    // bypass on channel 1
    bypass = 3'b010;
    send({10'h3FF, 10'h155, 10'h000}, 0, 0);
    bypass = 3'b000;
    cyc();
    check("t3_bypass", vout.tdata, {2'b00, 10'h000, 10'h155, 10'h3FF});
    drain();

    // 64x4 frame with random backpressure and gaps
    lat_chk  = 0;
    rand_rdy = 1;
    tlast_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      bypass = 3'($urandom);
      send(rpx(), i == 0, (i % 64) == 63);
      if ($urandom_range(3) == 0) idle(1);
    end
    bypass = 3'b000;
    rand_rdy = 0;
    vout.tready = 1'b1;
    drain();
    check("tlast_cnt", tlast_cnt, 4);
    lat_chk = 1;

    // swap request coinciding with an accepted frame start
    swap_req = 1'b1;
    send(rpx(), 1, 0);
    swap_req = 1'b0;
    check("t5_bank", active_bank, 0);
    check("t5_pend", swap_pending, 1);
    for (int i = 0; i < 3; i++) send(rpx(), 0, i == 2);
    check("t5_bank_mid", active_bank, 0);
    send(rpx(), 1, 0);
    check("t5_bank_next", active_bank, 1);
    check("t5_pend_clr", swap_pending, 0);
    drain();

    // reset mid-frame with two beats in flight and a swap pending
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    send(rpx(), 0, 0);
    send(rpx(), 0, 0);
    vout.tready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    vout.tready = 1'b1;
    check("t6_valid", vout.tvalid, 0);
    check("t6_pend", swap_pending, 0);
    check("t6_bank", active_bank, 0);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
